// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states, control vectors.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] ALU_OP_ADC = 4'd0;
   localparam logic [OP_W-1:0] ALU_OP_SBC = 4'd1;
   localparam logic [OP_W-1:0] ALU_OP_AND = 4'd2;
   localparam logic [OP_W-1:0] ALU_OP_ORA = 4'd3;
   localparam logic [OP_W-1:0] ALU_OP_EOR = 4'd4;
   localparam logic [OP_W-1:0] ALU_OP_LSR = 4'd5;
   localparam logic [OP_W-1:0] ALU_OP_ASL = 4'd6;
   localparam logic [OP_W-1:0] ALU_OP_INC = 4'd7;
   localparam logic [OP_W-1:0] ALU_OP_DEC = 4'd8;
   localparam logic [OP_W-1:0] ALU_OP_CMP = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

   // Strobes driven for one cycle while the ALU input registers load.
   typedef struct packed {
      logic sb_add;
      logic zero_add;
      logic db_add;
      logic db_n_add;
      logic addc;
      logic sums;
      logic ands;
      logic eors;
      logic ors;
      logic srs;
      logic db_zero;
   } load_ctl_t;

   // Result-cycle bus gate and flag write-enables.
   typedef struct packed {
      logic add_sb;
      logic c_we;
      logic v_we;
   } res_ctl_t;

   localparam int LOAD_W = $bits(load_ctl_t);
   localparam int RES_W  = $bits(res_ctl_t);

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= ALU_OP_CMP;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Decoder <-> ALU sequencer signal bundle; master is the decode/timing side.
// Latency: n/a (wiring only).
// Backpressure: none; requests are only taken while the sequencer accepts.
interface alu_sequencer_if;
   import alu_seq_pkg::*;

   logic            i_start;
   logic [OP_W-1:0] i_op;
   logic            i_ci;
   logic            i_acr;
   logic            i_avr;

   logic o_sb_add, o_0_add, o_db_add, o_db_n_add;
   logic o_1_addc;
   logic o_sums, o_ands, o_eors, o_ors, o_srs;
   logic o_db_zero;
   logic o_add_sb;
   logic o_c_we, o_v_we;
   logic o_c, o_v;
   logic o_busy, o_done, o_err;

   modport master (
      output i_start, i_op, i_ci, i_acr, i_avr,
      input  o_sb_add, o_0_add, o_db_add, o_db_n_add, o_1_addc,
             o_sums, o_ands, o_eors, o_ors, o_srs, o_db_zero,
             o_add_sb, o_c_we, o_v_we, o_c, o_v, o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_op, i_ci, i_acr, i_avr,
      output o_sb_add, o_0_add, o_db_add, o_db_n_add, o_1_addc,
             o_sums, o_ands, o_eors, o_ors, o_srs, o_db_zero,
             o_add_sb, o_c_we, o_v_we, o_c, o_v, o_busy, o_done, o_err
   );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational op -> load-cycle control vector and result-cycle enables.
// Latency: 0 cycles.
// Backpressure: none.
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic            ci,
   output load_ctl_t       load_ctl,
   output res_ctl_t        res_ctl
);

   always_comb begin
      load_ctl = '0;
      res_ctl  = '0;
      case (op)
         ALU_OP_ADC: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.db_add = 1'b1;
            load_ctl.sums   = 1'b1;
            load_ctl.addc   = ci;
            res_ctl         = '{add_sb: 1'b1, c_we: 1'b1, v_we: 1'b1};
         end
         ALU_OP_SBC: begin
            load_ctl.sb_add   = 1'b1;
            load_ctl.db_n_add = 1'b1;
            load_ctl.sums     = 1'b1;
            load_ctl.addc     = ci;
            res_ctl           = '{add_sb: 1'b1, c_we: 1'b1, v_we: 1'b1};
         end
         ALU_OP_AND: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.db_add = 1'b1;
            load_ctl.ands   = 1'b1;
            res_ctl.add_sb  = 1'b1;
         end
         ALU_OP_ORA: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.db_add = 1'b1;
            load_ctl.ors    = 1'b1;
            res_ctl.add_sb  = 1'b1;
         end
         ALU_OP_EOR: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.db_add = 1'b1;
            load_ctl.eors   = 1'b1;
            res_ctl.add_sb  = 1'b1;
         end
         ALU_OP_LSR: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.srs    = 1'b1;
            res_ctl         = '{add_sb: 1'b1, c_we: 1'b1, v_we: 1'b0};
         end
         // ASL adds the operand to itself: SB and DB carry the same value.
         ALU_OP_ASL: begin
            load_ctl.sb_add = 1'b1;
            load_ctl.db_add = 1'b1;
            load_ctl.sums   = 1'b1;
            res_ctl         = '{add_sb: 1'b1, c_we: 1'b1, v_we: 1'b0};
         end
         ALU_OP_INC: begin
            load_ctl.sb_add   = 1'b1;
            load_ctl.zero_add = 1'b1;
            load_ctl.sums     = 1'b1;
            load_ctl.addc     = 1'b1;
            res_ctl.add_sb    = 1'b1;
         end
         // DEC adds ~0x00 (= -1) by zeroing DB and loading its inverse.
         ALU_OP_DEC: begin
            load_ctl.sb_add   = 1'b1;
            load_ctl.db_n_add = 1'b1;
            load_ctl.db_zero  = 1'b1;
            load_ctl.sums     = 1'b1;
            res_ctl.add_sb    = 1'b1;
         end
         ALU_OP_CMP: begin
            load_ctl.sb_add   = 1'b1;
            load_ctl.db_n_add = 1'b1;
            load_ctl.sums     = 1'b1;
            load_ctl.addc     = 1'b1;
            res_ctl.c_we      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: LOAD strobes, then RESULT bus gate and flag writes.
// Latency: 2 cycles start -> done; one op per 2 cycles with back-to-back starts.
// Backpressure: i_start is ignored in LOAD; illegal ops are dropped with an err pulse.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_reset_n,
   alu_sequencer_if.slave bus
);

   state_e          state, state_nxt;
   logic [OP_W-1:0] op_q;
   logic            ci_q, c_q, v_q, err_q;
   logic            accept, legal, take;
   load_ctl_t       load_ctl, load_out;
   res_ctl_t        res_ctl, res_out;

   alu_op_decode u_dec (
      .op       (op_q),
      .ci       (ci_q),
      .load_ctl (load_ctl),
      .res_ctl  (res_ctl)
   );

   assign legal = op_legal(bus.i_op);
   assign take  = accept && legal;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_out  = '0;
      res_out   = '0;
      case (state)
         ST_IDLE: begin
            accept = bus.i_start;
            if (accept && legal) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            load_out  = load_ctl;
            state_nxt = ST_RESULT;
         end
         ST_RESULT: begin
            res_out   = res_ctl;
            accept    = bus.i_start;
            state_nxt = (accept && legal) ? ST_LOAD : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= ST_IDLE;
         op_q  <= '0;
         ci_q  <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= accept && !legal;
         if (take) begin
            op_q <= bus.i_op;
            ci_q <= bus.i_ci;
         end
         if (state == ST_RESULT) begin
            c_q <= bus.i_acr;
            v_q <= bus.i_avr;
         end
      end
   end

   assign bus.o_sb_add   = load_out.sb_add;
   assign bus.o_0_add    = load_out.zero_add;
   assign bus.o_db_add   = load_out.db_add;
   assign bus.o_db_n_add = load_out.db_n_add;
   assign bus.o_1_addc   = load_out.addc;
   assign bus.o_sums     = load_out.sums;
   assign bus.o_ands     = load_out.ands;
   assign bus.o_eors     = load_out.eors;
   assign bus.o_ors      = load_out.ors;
   assign bus.o_srs      = load_out.srs;
   assign bus.o_db_zero  = load_out.db_zero;
   assign bus.o_add_sb   = res_out.add_sb;
   assign bus.o_c_we     = res_out.c_we;
   assign bus.o_v_we     = res_out.v_we;

   // Flags pass straight through while the ALU result is live, then hold.
   assign bus.o_c    = (state == ST_RESULT) ? bus.i_acr : c_q;
   assign bus.o_v    = (state == ST_RESULT) ? bus.i_avr : v_q;
   assign bus.o_busy = (state == ST_LOAD) || (state == ST_RESULT);
   assign bus.o_done = (state == ST_RESULT);
   assign bus.o_err  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer against a table-driven op model.
module tb_alu_sequencer;

   localparam logic [3:0] ADC = 4'd0, SBC = 4'd1, AND = 4'd2, ORA = 4'd3, EOR = 4'd4;
   localparam logic [3:0] LSR = 4'd5, ASL = 4'd6, INC = 4'd7, DEC = 4'd8, CMP = 4'd9;

   logic i_clk = 1'b0;
   logic i_reset_n;
   int   checks = 0;
   int   errors = 0;
   logic c_hold, v_hold;

   always #5 i_clk = ~i_clk;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   // {11 load strobes, add_sb, c_we, v_we, c, v, busy, done, err}
   logic [18:0] obs;
   assign obs = {bus.o_sb_add, bus.o_0_add, bus.o_db_add, bus.o_db_n_add, bus.o_1_addc,
                 bus.o_sums, bus.o_ands, bus.o_eors, bus.o_ors, bus.o_srs, bus.o_db_zero,
                 bus.o_add_sb, bus.o_c_we, bus.o_v_we, bus.o_c, bus.o_v,
                 bus.o_busy, bus.o_done, bus.o_err};

   function automatic logic [10:0] load_bits(input logic [3:0] op, input logic ci);
      logic sb, z, db, dbn, cin, sum, a, e, o, sr, dz;
      sb  = (op <= CMP);
      z   = (op == INC);
      db  = op inside {ADC, AND, ORA, EOR, ASL};
      dbn = op inside {SBC, DEC, CMP};
      sum = op inside {ADC, SBC, ASL, INC, DEC, CMP};
      cin = (op inside {ADC, SBC}) ? ci : (op inside {INC, CMP});
      a   = (op == AND);
      e   = (op == EOR);
      o   = (op == ORA);
      sr  = (op == LSR);
      dz  = (op == DEC);
      return {sb, z, db, dbn, cin, sum, a, e, o, sr, dz};
   endfunction

   function automatic logic [2:0] res_bits(input logic [3:0] op);
      return {op != CMP, op inside {ADC, SBC, LSR, ASL, CMP}, op inside {ADC, SBC}};
   endfunction

   task automatic check(input string tag, input logic [18:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [3:0] op, input logic ci,
                        input logic acr, input logic avr);
      @(posedge i_clk);
      #1;
      bus.i_start = st;
      bus.i_op    = op;
      bus.i_ci    = ci;
      bus.i_acr   = acr;
      bus.i_avr   = avr;
   endtask

   task automatic chk_idle(input string tag, input logic err);
      #3;
      check(tag, {11'b0, 3'b0, c_hold, v_hold, 1'b0, 1'b0, err});
   endtask

   task automatic chk_load(input string tag, input logic [3:0] op, input logic ci);
      #3;
      check(tag, {load_bits(op, ci), 3'b0, c_hold, v_hold, 1'b1, 1'b0, 1'b0});
   endtask

   task automatic chk_result(input string tag, input logic [3:0] op, input logic acr, input logic avr);
      #3;
      check(tag, {11'b0, res_bits(op), acr, avr, 1'b1, 1'b1, 1'b0});
      c_hold = acr;
      v_hold = avr;
   endtask

   initial begin
      logic [3:0] op, nop;
      logic       ci, nci, acr, avr, chained;

      i_reset_n   = 1'b0;
      bus.i_start = 1'b1;
      bus.i_op    = ADC;
      bus.i_ci    = 1'b1;
      bus.i_acr   = 1'b1;
      bus.i_avr   = 1'b1;
      c_hold      = 1'b0;
      v_hold      = 1'b0;

      // Reset held with a pending request: nothing may move.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ADC, 1'b1, 1'b1, 1'b1);
         chk_idle("reset_hold", 1'b0);
      end
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      i_reset_n = 1'b1;
      chk_idle("reset_release", 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("idle_after_reset", 1'b0);

      // ADC with carry in
      drive(1'b1, ADC, 1'b1, 1'b0, 1'b0);
      chk_idle("adc_accept", 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_load("adc_load", ADC, 1'b1);
      drive(1'b0, ADC, 1'b0, 1'b1, 1'b0);
      chk_result("adc_result", ADC, 1'b1, 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b1);
      chk_idle("adc_flag_hold", 1'b0);

      // CMP forces carry-in regardless of C, no ADD->SB, no V write
      drive(1'b1, CMP, 1'b0, 1'b0, 1'b0);
      chk_idle("cmp_accept", 1'b0);
      drive(1'b0, CMP, 1'b0, 1'b1, 1'b1);
      chk_load("cmp_load", CMP, 1'b0);
      drive(1'b0, CMP, 1'b0, 1'b0, 1'b1);
      chk_result("cmp_result", CMP, 1'b0, 1'b1);
      drive(1'b0, CMP, 1'b0, 1'b1, 1'b0);
      chk_idle("cmp_after", 1'b0);

      // AND then EOR back-to-back; starts during LOAD must be ignored
      drive(1'b1, AND, 1'b0, 1'b0, 1'b0);
      chk_idle("b2b_accept", 1'b0);
      drive(1'b1, LSR, 1'b1, 1'b0, 1'b0);
      chk_load("b2b_and_load", AND, 1'b0);
      drive(1'b1, EOR, 1'b1, 1'b1, 1'b1);
      chk_result("b2b_and_done", AND, 1'b1, 1'b1);
      drive(1'b1, ADC, 1'b0, 1'b0, 1'b0);
      chk_load("b2b_eor_load", EOR, 1'b1);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_result("b2b_eor_done", EOR, 1'b0, 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("b2b_idle", 1'b0);

      // Illegal op 12
      drive(1'b1, 4'd12, 1'b1, 1'b0, 1'b0);
      chk_idle("ill_accept", 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("ill_err", 1'b1);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("ill_after", 1'b0);

      // Give the held flags a nonzero value, then reset during LOAD of SBC
      drive(1'b1, LSR, 1'b0, 1'b0, 1'b0);
      chk_idle("lsr_accept", 1'b0);
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_load("lsr_load", LSR, 1'b0);
      drive(1'b1, SBC, 1'b1, 1'b1, 1'b1);
      chk_result("lsr_result_chain_sbc", LSR, 1'b1, 1'b1);
      drive(1'b0, ADC, 1'b0, 1'b1, 1'b1);
      chk_load("sbc_load", SBC, 1'b1);
      #1;
      i_reset_n = 1'b0;
      c_hold    = 1'b0;
      v_hold    = 1'b0;
      #1;
      check("sbc_reset_immediate", 19'b0);
      drive(1'b0, ADC, 1'b0, 1'b1, 1'b1);
      chk_idle("sbc_reset_no_done", 1'b0);
      i_reset_n = 1'b1;
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("sbc_reset_release", 1'b0);

      // Randomized transactions, optionally chained from the RESULT cycle
      chained = 1'b0;
      nop     = ADC;
      nci     = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (!chained) begin
            op = 4'($urandom_range(0, 11));
            ci = 1'($urandom);
            drive(1'b1, op, ci, 1'($urandom), 1'($urandom));
            chk_idle("rnd_accept", 1'b0);
         end else begin
            op = nop;
            ci = nci;
         end
         if (op <= CMP) begin
            drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk_load("rnd_load", op, ci);
            chained = ($urandom_range(0, 1) == 1);
            nop     = 4'($urandom_range(0, 11));
            nci     = 1'($urandom);
            acr     = 1'($urandom);
            avr     = 1'($urandom);
            drive(chained, nop, nci, acr, avr);
            chk_result("rnd_result", op, acr, avr);
         end else begin
            drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk_idle("rnd_err", 1'b1);
            chained = 1'b0;
         end
      end
      drive(1'b0, ADC, 1'b0, 1'b0, 1'b0);
      chk_idle("rnd_final_idle", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
